stream_demux_1to2: RTL and testbench

- Inverse of the team's 2:1 mux: one input stream is steered to one of two output streams (A or B), selected per packet.
- Valid/ready handshake on all three streams; a one-entry registered output buffer per destination.
- Select is sampled on a packet's first beat and held until its last beat, so packets are never split across outputs.
- Sits between a shared producer and two consumers; per-output beat counters for debug.

---
 rtl/stream_demux_1to2.sv | 112 +++++++++++
 tb/tb_stream_demux_1to2.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1to2.sv
// 1:2 valid/ready stream demultiplexer with per-packet route lock.
// Each output has a one-entry registered buffer and a debug beat counter.
module stream_demux_1to2 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] a_data,
  output logic              a_last,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] b_data,
  output logic              b_last,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_data_q, b_data_q;
  logic                a_last_q, b_last_q;
  logic                a_valid_q, b_valid_q;
  logic [CNT_W-1:0]    a_count_q, b_count_q;

  logic                route_b;
  logic                in_hs;
  logic                a_load, b_load;

  // Select only matters between packets; once locked, the state decides.
  assign route_b  = (state_q == LOCK_B) || ((state_q == IDLE) && in_sel);
  assign in_ready = route_b ? (!b_valid_q || b_ready) : (!a_valid_q || a_ready);
  assign in_hs    = in_valid && in_ready;
  assign a_load   = in_hs && !route_b;
  assign b_load   = in_hs && route_b;

  always_comb begin
    state_d = state_q;
    if (in_hs) begin
      if (in_last) begin
        state_d = IDLE;
      end else if (state_q == IDLE) begin
        state_d = in_sel ? LOCK_B : LOCK_A;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A full buffer being drained can be refilled on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data_q  <= '0;
      a_last_q  <= 1'b0;
      a_valid_q <= 1'b0;
      a_count_q <= '0;
    end else begin
      if (a_load) begin
        a_data_q  <= in_data;
        a_last_q  <= in_last;
        a_valid_q <= 1'b1;
        a_count_q <= a_count_q + 1'b1;
      end else if (a_ready) begin
        a_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_data_q  <= '0;
      b_last_q  <= 1'b0;
      b_valid_q <= 1'b0;
      b_count_q <= '0;
    end else begin
      if (b_load) begin
        b_data_q  <= in_data;
        b_last_q  <= in_last;
        b_valid_q <= 1'b1;
        b_count_q <= b_count_q + 1'b1;
      end else if (b_ready) begin
        b_valid_q <= 1'b0;
      end
    end
  end

  assign a_data  = a_data_q;
  assign a_last  = a_last_q;
  assign a_valid = a_valid_q;
  assign b_data  = b_data_q;
  assign b_last  = b_last_q;
  assign b_valid = b_valid_q;
  assign a_count = a_count_q;
  assign b_count = b_count_q;
  assign busy    = (state_q != IDLE) || a_valid_q || b_valid_q;

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed bench for stream_demux_1to2: routing, packet lock, backpressure,
// independent drain, asynchronous mid-packet reset and counter wrap.
module tb_stream_demux_1to2;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_sel;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a_data;
  logic              a_last;
  logic              a_valid;
  logic              a_ready;
  logic [DATA_W-1:0] b_data;
  logic              b_last;
  logic              b_valid;
  logic              b_ready;
  logic [CNT_W-1:0]  a_count;
  logic [CNT_W-1:0]  b_count;
  logic              busy;

  int checks_cnt;
  int errors_cnt;

  stream_demux_1to2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_last   (a_last),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_last   (b_last),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse placed mid-cycle, away from the active edge.
  task automatic pulse_reset();
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  // Present one beat, wait (bounded) for in_ready, complete the handshake.
  task automatic send_beat(input logic [7:0] d, input logic s, input logic l);
    int n;
    in_data  = d;
    in_sel   = s;
    in_last  = l;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    $display("beat data=0x%02h sel=%0d last=%0d a_cnt=%0d b_cnt=%0d", d, s, l, a_count, b_count);
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n    = 1'b0;
    in_data  = '0;
    in_sel   = 1'b0;
    in_last  = 1'b0;
    in_valid = 1'b0;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    #2;
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_a_data",  32'(a_data),  32'd0);
    check("rst_b_last",  32'(b_last),  32'd0);
    check("rst_a_count", 32'(a_count), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    tick();

    // Single-beat routing
    send_beat(8'h5A, 1'b0, 1'b1);
    check("sb_a_valid", 32'(a_valid), 32'd1);
    check("sb_a_data",  32'(a_data),  32'h5A);
    check("sb_a_last",  32'(a_last),  32'd1);
    check("sb_b_valid", 32'(b_valid), 32'd0);
    check("sb_a_count", 32'(a_count), 32'd1);
    send_beat(8'hC3, 1'b1, 1'b1);
    check("sb_b_valid2", 32'(b_valid), 32'd1);
    check("sb_b_data2",  32'(b_data),  32'hC3);
    check("sb_a_drained", 32'(a_valid), 32'd0);
    check("sb_b_count",  32'(b_count), 32'd1);
    tick();
    check("sb_idle_busy", 32'(busy), 32'd0);

    // Packet lock: sel ignored after first beat
    pulse_reset();
    send_beat(8'h11, 1'b1, 1'b0);
    check("pl_b_data1", 32'(b_data), 32'h11);
    check("pl_busy1",   32'(busy),   32'd1);
    send_beat(8'h22, 1'b0, 1'b0);
    check("pl_b_data2", 32'(b_data), 32'h22);
    check("pl_a_valid2", 32'(a_valid), 32'd0);
    send_beat(8'h33, 1'b1, 1'b1);
    check("pl_b_data3", 32'(b_data), 32'h33);
    check("pl_b_last3", 32'(b_last), 32'd1);
    check("pl_a_count", 32'(a_count), 32'd0);
    check("pl_b_count", 32'(b_count), 32'd3);
    check("pl_busy3",   32'(busy),   32'd1);
    tick();
    check("pl_busy_done", 32'(busy), 32'd0);

    // Backpressure on A
    pulse_reset();
    a_ready = 1'b0;
    send_beat(8'h01, 1'b0, 1'b0);
    check("bp_a_valid", 32'(a_valid), 32'd1);
    check("bp_a_data1", 32'(a_data),  32'h01);
    in_data = 8'h02; in_sel = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    #1;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    check("bp_a_data_held", 32'(a_data), 32'h01);
    check("bp_a_count_held", 32'(a_count), 32'd1);
    a_ready = 1'b1;
    #1;
    check("bp_in_ready_high", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    $display("beat data=0x02 sel=1 last=1 (locked to A) a_cnt=%0d b_cnt=%0d", a_count, b_count);
    check("bp_a_data2",  32'(a_data),  32'h02);
    check("bp_a_valid2", 32'(a_valid), 32'd1);
    check("bp_a_last2",  32'(a_last),  32'd1);
    check("bp_a_count2", 32'(a_count), 32'd2);
    check("bp_b_valid",  32'(b_valid), 32'd0);
    tick();
    check("bp_no_dup", 32'(a_valid), 32'd0);

    // Independent drain: B stalled while A streams
    pulse_reset();
    b_ready = 1'b0;
    send_beat(8'h77, 1'b1, 1'b1);
    in_data = 8'hAA; in_sel = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    #1;
    check("id_in_ready_aa", 32'(in_ready), 32'd1);
    tick();
    check("id_a_data_aa", 32'(a_data), 32'hAA);
    in_data = 8'hBB;
    #1;
    check("id_in_ready_bb", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    $display("beats 0xAA,0xBB streamed to A a_cnt=%0d b_cnt=%0d", a_count, b_count);
    check("id_a_data_bb", 32'(a_data),  32'hBB);
    check("id_a_valid",   32'(a_valid), 32'd1);
    check("id_b_data",    32'(b_data),  32'h77);
    check("id_b_valid",   32'(b_valid), 32'd1);
    check("id_a_count",   32'(a_count), 32'd2);

    // Reset mid-packet releases lock
    pulse_reset();
    b_ready = 1'b1;
    send_beat(8'h10, 1'b1, 1'b0);
    send_beat(8'h20, 1'b1, 1'b0);
    b_ready = 1'b0;
    check("rm_b_count_pre", 32'(b_count), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    check("rm_b_valid", 32'(b_valid), 32'd0);
    check("rm_b_count", 32'(b_count), 32'd0);
    check("rm_busy",    32'(busy),    32'd0);
    #1 rst_n = 1'b1;
    tick();
    a_ready = 1'b1;
    send_beat(8'h30, 1'b0, 1'b1);
    check("rm_a_valid", 32'(a_valid), 32'd1);
    check("rm_a_data",  32'(a_data),  32'h30);
    check("rm_b_after", 32'(b_valid), 32'd0);

    // Counter wrap with CNT_W=4
    pulse_reset();
    for (int i = 0; i < 17; i++) send_beat(8'(i), 1'b0, 1'b1);
    check("cw_a_count", 32'(a_count), 32'd1);
    check("cw_b_count", 32'(b_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule
